mmio_arbiter: RTL and testbench

Shares one byte-wide MMIO peripheral bus (the `i_mmio_*`/`o_mmio_*` interface used by GPIO and other MMIO slaves) between `NUM_REQ` requesters, e.g. the core load/store unit and a debug port. Each requester issues a single-byte read or write through a req/ack handshake. The arbiter picks one winner, drives exactly one strobe cycle on the shared bus, captures read data, and returns an ack. Addresses outside the configured MMIO window complete with an error and produce no bus strobe.

---
 rtl/mmio_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mmio_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_arbiter.sv
// Arbitrates NUM_REQ single-byte req/ack requesters onto one shared MMIO bus.
// Define MMIO_ARB_ROUND_ROBIN_EN for round-robin; otherwise the lowest index wins.
module mmio_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter logic [31:0] ADDR_SPAN = 32'h0000_1000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ-1:0]   i_req_we,
  input  logic [NUM_REQ*32-1:0] i_req_addr,
  input  logic [NUM_REQ*8-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic                 o_err,
  output logic [7:0]           o_rdata,
  output logic [31:0]          o_mmio_addr,
  output logic [7:0]           o_mmio_data_out,
  input  logic [7:0]           i_mmio_data_in,
  output logic                 o_mmio_we,
  output logic                 o_mmio_re
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      lat_addr_q;
  logic [7:0]       lat_wdata_q;
  logic             lat_we_q;
  logic [IDX_W-1:0] lat_idx_q;
  logic             lat_inrange_q;
  logic [7:0]       rdata_q;

  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  logic [31:0]      sel_addr;
  logic [7:0]       sel_wdata;
  logic             sel_we;
  logic             sel_inrange;

  logic [32:0] win_lo;
  logic [32:0] win_hi;
  assign win_lo = {1'b0, BASE_ADDR};
  assign win_hi = {1'b0, BASE_ADDR} + {1'b0, ADDR_SPAN};

`ifdef MMIO_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr_q;

  // Scan starts one past the last grant so every requester is reached within NUM_REQ grants.
  always_comb begin
    int unsigned cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    sel_addr    = '0;
    sel_wdata   = '0;
    sel_we      = 1'b0;
    cand        = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!grant_found && i_req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
        sel_addr    = i_req_addr[32*cand +: 32];
        sel_wdata   = i_req_wdata[8*cand +: 8];
        sel_we      = i_req_we[cand];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rr_ptr_q <= IDX_W'(NUM_REQ - 1);
    end else if (state_q == IDLE && grant_found) begin
      rr_ptr_q <= grant_idx;
    end
  end
`else
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    sel_addr    = '0;
    sel_wdata   = '0;
    sel_we      = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && i_req[i]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(i);
        sel_addr    = i_req_addr[32*i +: 32];
        sel_wdata   = i_req_wdata[8*i +: 8];
        sel_we      = i_req_we[i];
      end
    end
  end
`endif

  // 33-bit compare so BASE_ADDR+ADDR_SPAN cannot wrap; a zero span rejects everything.
  assign sel_inrange = ({1'b0, sel_addr} >= win_lo) && ({1'b0, sel_addr} < win_hi);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    o_mmio_we = 1'b0;
    o_mmio_re = 1'b0;
    o_ack     = '0;
    o_err     = 1'b0;
    o_rdata   = '0;
    case (state_q)
      IDLE: begin
        if (grant_found) state_d = ACCESS;
      end
      ACCESS: begin
        o_mmio_we = lat_inrange_q & lat_we_q;
        o_mmio_re = lat_inrange_q & ~lat_we_q;
        state_d   = RESP;
      end
      RESP: begin
        o_ack[lat_idx_q] = 1'b1;
        o_err            = ~lat_inrange_q;
        o_rdata          = rdata_q;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      lat_addr_q    <= '0;
      lat_wdata_q   <= '0;
      lat_we_q      <= 1'b0;
      lat_idx_q     <= '0;
      lat_inrange_q <= 1'b0;
      rdata_q       <= '0;
    end else begin
      if (state_q == IDLE && grant_found) begin
        lat_addr_q    <= sel_addr;
        lat_wdata_q   <= sel_wdata;
        lat_we_q      <= sel_we;
        lat_idx_q     <= grant_idx;
        lat_inrange_q <= sel_inrange;
      end
      if (state_q == ACCESS) begin
        rdata_q <= (lat_inrange_q && !lat_we_q) ? i_mmio_data_in : 8'h00;
      end
    end
  end

  assign o_mmio_addr     = lat_addr_q;
  assign o_mmio_data_out = lat_wdata_q;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench for mmio_arbiter: vector table of single transactions plus
// contention, reset-during-access and early-drop sequences.
module tb_mmio_arbiter;

  localparam int unsigned NREQ = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_we;
  logic [NREQ*32-1:0] req_addr;
  logic [NREQ*8-1:0] req_wdata;
  logic [NREQ-1:0]   ack;
  logic              err;
  logic [7:0]        rdata;
  logic [31:0]       mmio_addr;
  logic [7:0]        mmio_dout;
  logic [7:0]        mmio_din;
  logic              mmio_we;
  logic              mmio_re;

  int checks = 0;
  int errors = 0;

  mmio_arbiter #(
    .NUM_REQ  (NREQ),
    .BASE_ADDR(32'h2000_0000),
    .ADDR_SPAN(32'h0000_1000)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req          (req),
    .i_req_we       (req_we),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_ack          (ack),
    .o_err          (err),
    .o_rdata        (rdata),
    .o_mmio_addr    (mmio_addr),
    .o_mmio_data_out(mmio_dout),
    .i_mmio_data_in (mmio_din),
    .o_mmio_we      (mmio_we),
    .o_mmio_re      (mmio_re)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave always drives a value, so writes and errors must still return 0.
  assign mmio_din = (mmio_addr == 32'h2000_0004) ? 8'hC3 : (mmio_addr[7:0] ^ 8'hA5);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int unsigned idx;
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic        exp_err;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic set_req(input int unsigned k, input logic we, input logic [31:0] a, input logic [7:0] d);
    req_we[k]           = we;
    req_addr[32*k +: 32] = a;
    req_wdata[8*k +: 8]  = d;
    req[k]              = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [NREQ-1:0] exp_ack;
    exp_ack = '0;
    exp_ack[v.idx] = 1'b1;
    @(negedge clk);
    set_req(v.idx, v.we, v.addr, v.wdata);
    @(negedge clk);
    check("access_we",   {31'b0, mmio_we}, {31'b0, v.we & ~v.exp_err});
    check("access_re",   {31'b0, mmio_re}, {31'b0, ~v.we & ~v.exp_err});
    check("access_addr", mmio_addr, v.addr);
    check("access_ack",  {30'b0, ack}, 32'd0);
    if (v.we) check("access_wdata", {24'b0, mmio_dout}, {24'b0, v.wdata});
    @(negedge clk);
    check("resp_ack",   {30'b0, ack}, {30'b0, exp_ack});
    check("resp_err",   {31'b0, err}, {31'b0, v.exp_err});
    check("resp_rdata", {24'b0, rdata}, {24'b0, v.exp_rdata});
    check("resp_strobe", {30'b0, mmio_we, mmio_re}, 32'd0);
    req = '0;
    @(negedge clk);
    check("idle_ack", {30'b0, ack}, 32'd0);
    check("idle_addr_hold", mmio_addr, v.addr);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int unsigned acks_seen;
    int unsigned we_seen;
    int unsigned grant_log[$];
    int unsigned exp_grant[4];

    vecs[0] = '{0, 1'b1, 32'h2000_0000, 8'h5A, 1'b0, 8'h00};
    vecs[1] = '{1, 1'b0, 32'h2000_0004, 8'h00, 1'b0, 8'hC3};
    vecs[2] = '{0, 1'b1, 32'h3000_0000, 8'h77, 1'b1, 8'h00};
    vecs[3] = '{1, 1'b0, 32'h2000_0FFF, 8'h00, 1'b0, 8'h5A};
    vecs[4] = '{0, 1'b0, 32'h2000_1000, 8'h00, 1'b1, 8'h00};
    vecs[5] = '{1, 1'b0, 32'h1FFF_FFFF, 8'h00, 1'b1, 8'h00};
    vecs[6] = '{0, 1'b0, 32'h2000_0010, 8'h00, 1'b0, 8'hB5};
    vecs[7] = '{1, 1'b1, 32'h2000_0020, 8'h3C, 1'b0, 8'h00};

    rst = 1'b0;
    req = '0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    #12;
    check("rst_ack",   {30'b0, ack}, 32'd0);
    check("rst_err",   {31'b0, err}, 32'd0);
    check("rst_rdata", {24'b0, rdata}, 32'd0);
    check("rst_addr",  mmio_addr, 32'd0);
    check("rst_dout",  {24'b0, mmio_dout}, 32'd0);
    check("rst_strobe", {30'b0, mmio_we, mmio_re}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Contention: both requesters held for four transactions from a fresh reset.
    pulse_reset();
    set_req(0, 1'b1, 32'h2000_0100, 8'h11);
    set_req(1, 1'b0, 32'h2000_0200, 8'h00);
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (ack[0]) grant_log.push_back(0);
      if (ack[1]) grant_log.push_back(1);
    end
    req = '0;
`ifdef MMIO_ARB_ROUND_ROBIN_EN
    exp_grant = '{0, 1, 0, 1};
`else
    exp_grant = '{0, 0, 0, 0};
`endif
    check("cont_count", grant_log.size(), 32'd4);
    for (int g = 0; g < 4; g++) begin
      if (g < grant_log.size()) check("cont_grant", grant_log[g], exp_grant[g]);
    end
    @(negedge clk);
    @(negedge clk);

    // Reset during ACCESS: strobes and bus drop at once, no ack; pending req0 served afterwards.
    pulse_reset();
    set_req(0, 1'b1, 32'h2000_0008, 8'h99);
    @(negedge clk);
    check("mid_we_before", {31'b0, mmio_we}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("mid_strobe", {30'b0, mmio_we, mmio_re}, 32'd0);
    check("mid_addr",   mmio_addr, 32'd0);
    check("mid_dout",   {24'b0, mmio_dout}, 32'd0);
    @(negedge clk);
    check("mid_ack_in_rst", {30'b0, ack}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_post_we",   {31'b0, mmio_we}, 32'd1);
    check("mid_post_addr", mmio_addr, 32'h2000_0008);
    @(negedge clk);
    check("mid_post_ack",  {30'b0, ack}, 32'd1);
    req = '0;
    @(negedge clk);

    // Early drop: req0 removed after the sampling edge still gets one strobe and one ack.
    set_req(0, 1'b1, 32'h2000_000C, 8'h42);
    acks_seen = 0;
    we_seen   = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mmio_we) we_seen++;
      if (ack[0])  acks_seen++;
      req = '0;
    end
    check("drop_strobes", we_seen, 32'd1);
    check("drop_acks",    acks_seen, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
